// File: rtl/fetch_pq.sv
// fetch_pq: fetch stage holding the PC and buffering {pc, instr} pairs in a DEPTH-entry prefetch queue.
// Ports: clk, reset (sync, active-high); PCSrc_F/PCBranch_F redirect; imem_addr_F/imem_req_F/imem_data_F
// instruction memory side; instr_D/pc_D/valid_D/ready_D decode handshake; count queue occupancy.
// Optional FETCH_PERF_CNT_EN adds saturating perf_fetched, perf_redirects, perf_stall counters.
module fetch_pq #(
  parameter int N = 64,
  parameter int W = 32,
  parameter int DEPTH = 4,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       PCSrc_F,
  input  logic [N-1:0]               PCBranch_F,
  output logic [N-1:0]               imem_addr_F,
  output logic                       imem_req_F,
  input  logic [W-1:0]               imem_data_F,
  output logic [W-1:0]               instr_D,
  output logic [N-1:0]               pc_D,
  output logic                       valid_D,
  input  logic                       ready_D,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]                perf_fetched,
  output logic [31:0]                perf_redirects,
  output logic [31:0]                perf_stall,
`endif
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [N-1:0] pc;
  logic [N-1:0] pc_mem [DEPTH];
  logic [W-1:0] ins_mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic pop, push;
  assign imem_addr_F = pc;
  assign valid_D = count != '0;
  assign pop = valid_D & ready_D;
  // a pop frees a slot in the same cycle, so a full queue still fetches at full rate
  assign imem_req_F = !reset & !PCSrc_F & ((count < CW'(DEPTH)) | pop);
  assign push = imem_req_F;
  // head entry is held untouched while empty, so these outputs stay stable
  assign instr_D = ins_mem[rd];
  assign pc_D = pc_mem[rd];
  always_ff @(posedge clk)
    if (push) begin
      pc_mem[wr] <= pc;
      ins_mem[wr] <= imem_data_F;
    end
  always_ff @(posedge clk)
    if (reset) begin
      pc <= RESET_PC;
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else if (PCSrc_F) begin
      pc <= {PCBranch_F[N-1:2], 2'b00};
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wr <= wr + AW'(1);
        pc <= pc + N'(4);
      end
      if (pop) rd <= rd + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk)
    if (reset) begin
      perf_fetched <= '0;
      perf_redirects <= '0;
      perf_stall <= '0;
    end else begin
      if (push && !(&perf_fetched)) perf_fetched <= perf_fetched + 32'd1;
      if (PCSrc_F && !(&perf_redirects)) perf_redirects <= perf_redirects + 32'd1;
      if (count == CW'(DEPTH) && !pop && !(&perf_stall)) perf_stall <= perf_stall + 32'd1;
    end
`endif
endmodule

// File: doc/fetch_pq.md
# fetch_pq

Parametrised fetch stage with a prefetch queue, successor to the single-register fetch unit. It holds the program counter, presents it to instruction memory every cycle the queue has room, and buffers fetched {PC, instruction} pairs in a DEPTH-entry FIFO. The FIFO feeds decode over a valid/ready handshake. A branch redirect reloads the PC and flushes the queue. It sits between instruction memory and the decode stage.

## Interface
- N, 64: address/PC width.
- W, 32: instruction width.
- DEPTH, 4: queue entries; power of two, ≥2.
- RESET_PC, 0: PC value after reset; bits [1:0] must be 0.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  reset; synchronous, active-high.
- PCSrc_F  in  1  redirect request.
- PCBranch_F  in  N  redirect target; bits [1:0] are ignored and treated as 0.
- imem_addr_F  out  N  current fetch PC, driven straight from the PC register.
- imem_req_F  out  1  fetch request this cycle.
- imem_data_F  in  W  instruction at imem_addr_F; combinational read, same cycle.
- instr_D  out  W  instruction at queue head.
- pc_D  out  N  PC of queue head.
- valid_D  out  1  queue head valid.
- ready_D  in  1  decode accepts head.
- count  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- pop = valid_D & ready_D.
- imem_req_F = !reset & !PCSrc_F & (count < DEPTH | pop).
- push = imem_req_F. On push, the FIFO writes {imem_addr_F, imem_data_F} at the tail and PC <= PC + 4, modulo 2^N (wraps 2^N−4 → 0).
- No push: PC holds. imem_addr_F stays stable while the queue is full.
- Redirect (PCSrc_F=1, reset=0):
  - PC <= {PCBranch_F[N-1:2], 2'b00}.
  - Queue flushed: count <= 0, read and write pointers <= 0.
  - No push this cycle.
  - Any pop in the same cycle is discarded: the handshake completes, but the entry is lost with the flush.
- Priority: reset > redirect > push/pop.
- Push and pop in the same cycle: count is unchanged. This is legal when full (throughput 1/cycle) and when count=1.
- valid_D = (count != 0). instr_D/pc_D come from the head entry. When valid_D=0 their contents are don't-care, but they must be held stable.
- Reset values: PC=RESET_PC, count=0, pointers=0, valid_D=0, imem_req_F=0, imem_addr_F=RESET_PC.
- Reset asserted mid-operation: queue contents are discarded on the next edge, identical to power-on reset.

## Timing
- Fetch-to-decode latency: 1 cycle. An instruction pushed at edge k appears on instr_D/pc_D after edge k if it is the head entry.
- After reset deasserts at edge r:
  - first push occurs at edge r+1;
  - valid_D=1 after edge r+1 with pc_D=RESET_PC.
- Redirect sampled at edge k:
  - after edge k: imem_addr_F=target, valid_D=0;
  - after edge k+1: valid_D=1, pc_D=target.
- Stall: with ready_D=0, the queue fills in DEPTH cycles, then imem_req_F=0.
- When ready_D rises with the queue full, the pop and the refill push occur in that same cycle.

## Configuration
- FETCH_PERF_CNT_EN defined: adds three 32-bit outputs, all reset to 0, cleared by reset, saturating at 2^32−1:
  - perf_fetched: increments on each push.
  - perf_redirects: increments on each accepted redirect.
  - perf_stall: increments in each cycle with count==DEPTH and no pop.
- FETCH_PERF_CNT_EN undefined: the three ports and their counters are absent. All other behaviour is identical.

## Test plan
- Reset held 5 cycles, then released with ready_D=1 → imem_addr_F steps 0,4,8,…; valid_D=1 from the first cycle after release; pc_D=0,4,8,… with matching instr_D.
- ready_D=0 from release, DEPTH=4 → count reaches 4 after 4 pushes, imem_req_F=0, imem_addr_F holds 16. ready_D=1 → pc_D 0,4,8,12,16,… with no gaps or duplicates.
- Redirect: PCBranch_F=10016, PCSrc_F=1 for one cycle at cycle 10 with count=3 → next cycle count=0, valid_D=0, imem_addr_F=10016; the cycle after, pc_D=10016, then 10020, 10024.
- Full queue with ready_D=1 held → count stays 4, one pop and one push per cycle for 10 cycles, pc_D strictly +4 per cycle.
- Boundary cases:
  - reset asserted with count=3 → next cycle count=0, valid_D=0, imem_addr_F=RESET_PC;
  - redirect to 2^64−4 → next pushed PC is 0;
  - PCBranch_F=10019 → target 10016.
- With FETCH_PERF_CNT_EN:
  - 6 pushes, 1 redirect, 3 full-stall cycles → perf_fetched=6, perf_redirects=1, perf_stall=3;
  - reset → all three counters 0.
